// File: rtl/cw_rbg_sched.sv
// cw_rbg_sched: codeword-selection scheduler.
// Sequences the codeword ROM preload, tracks slot/symbol/RBG boundaries on the
// subcarrier stream, stores sorted per-RBG beam indices and replays them on
// symbols >= 1 as a beam-index vector followed by an RBG-load strobe.
// Optional underflow error reporting is enabled by defining CW_RBG_SCHED_ERR_EN.
module cw_rbg_sched #(
    parameter int unsigned BEAM     = 16,
    parameter int unsigned SYMB_NUM = 14,
    parameter int unsigned RBG_NUM  = 17,
    parameter int unsigned RBG_LEN  = 192
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_slot_start,
    input  logic                i_sym_start,
    input  logic                i_data_vld,
    input  logic                i_beam_vld,
    input  logic [BEAM*8-1:0]   i_beam_idx,
    output logic                o_beam_rdy,
    input  logic                i_cw_tvalid,
    output logic                o_cw_enable,
    output logic [7:0]          o_symb_idx,
    output logic                o_symb_clr,
    output logic                o_symb_1st,
    output logic [BEAM*8-1:0]   o_beam_idx,
    output logic                o_rbg_load,
    output logic [7:0]          o_rbg_idx,
    output logic                o_err_underflow,
    output logic [15:0]         o_err_cnt
);

    localparam int unsigned BW     = BEAM * 8;
    localparam int unsigned AW     = (RBG_NUM > 1) ? $clog2(RBG_NUM) : 1;
    localparam logic [7:0]  SymMax = 8'(SYMB_NUM - 1);
    localparam logic [7:0]  RbgNum = 8'(RBG_NUM);
    localparam logic [7:0]  RbgMax = 8'(RBG_NUM - 1);
    localparam logic [15:0] ScMax  = 16'(RBG_LEN - 1);

    typedef enum logic [1:0] {StPreload, StWaitSlot, StRun} state_e;

    state_e         state_q, state_d;
    logic           cw_enable_q;
    logic           symb_clr_q;
    logic [7:0]     sym_cnt_q;
    logic [7:0]     symb_idx_q;
    logic [7:0]     wr_ptr_q;
    logic [7:0]     rbg_cnt_q;
    logic [15:0]    sc_cnt_q;
    logic [BW-1:0]  beam_idx_q;
    logic           load_p1_q;
    logic           load_q;
    logic [BW-1:0]  table_q [RBG_NUM];

    logic           slot_fire;
    logic           active;
    logic           sym_fire;
    logic           sc_wrap;
    logic           wrap;
    logic           bnd;
    logic           replay;
    logic           wr_en;
    logic           fwd;
    logic           hit;
    logic [7:0]     sym_base;
    logic [7:0]     rbg_next;
    logic [7:0]     cur_sym;
    logic [BW-1:0]  rd_data;

    // Next-state logic for the preload / wait / run sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            StPreload:  if (i_cw_tvalid) state_d = StWaitSlot;
            StWaitSlot: if (i_slot_start) state_d = StRun;
            StRun:      state_d = StRun;
            default:    state_d = StPreload;
        endcase
    end

    // Event decode, boundary detection and table read with write forwarding
    always_comb begin
        slot_fire  = i_slot_start && (state_q != StPreload);
        // The slot-start cycle itself already counts as running
        active     = (state_q == StRun) || slot_fire;
        sym_fire   = active && i_sym_start;
        sym_base   = slot_fire ? 8'd0 : sym_cnt_q;
        sc_wrap    = i_data_vld && (sc_cnt_q == ScMax);
        // Past the last RBG the counter keeps wrapping but no boundary is raised
        wrap       = active && !sym_fire && sc_wrap && (rbg_cnt_q < RbgMax);
        bnd        = sym_fire || wrap;
        rbg_next   = sym_fire ? 8'd0 : rbg_cnt_q + 8'd1;
        // A symbol start belongs to the symbol being loaded, not the old one
        cur_sym    = sym_fire ? sym_base : symb_idx_q;
        replay     = bnd && (cur_sym != 8'd0);
        o_beam_rdy = (state_q == StRun) && (wr_ptr_q < RbgNum);
        wr_en      = i_beam_vld && o_beam_rdy;
        fwd        = wr_en && (rbg_next == wr_ptr_q);
        hit        = (rbg_next < wr_ptr_q) || fwd;
        rd_data    = fwd ? i_beam_idx : table_q[rbg_next[AW-1:0]];
    end

    // Sequencer state and registered preload enable (low during reset)
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= StPreload;
            cw_enable_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cw_enable_q <= (state_d == StPreload);
        end
    end

    // Slot clear pulse and saturating symbol counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            symb_clr_q <= 1'b0;
            sym_cnt_q  <= 8'd0;
            symb_idx_q <= 8'd0;
        end else begin
            symb_clr_q <= slot_fire;
            if (sym_fire) begin
                symb_idx_q <= sym_base;
                sym_cnt_q  <= (sym_base < SymMax) ? sym_base + 8'd1 : SymMax;
            end else if (slot_fire) begin
                sym_cnt_q <= 8'd0;
            end
        end
    end

    // Beam table write pointer
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= 8'd0;
        end else if (slot_fire) begin
            wr_ptr_q <= 8'd0;
        end else if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + 8'd1;
        end
    end

    // Beam table storage; contents are qualified by the write pointer
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            table_q[wr_ptr_q[AW-1:0]] <= i_beam_idx;
        end
    end

    // RBG tracking, beam vector replay and the two-stage load strobe
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sc_cnt_q   <= 16'd0;
            rbg_cnt_q  <= 8'd0;
            beam_idx_q <= '0;
            load_p1_q  <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            load_p1_q <= replay;
            load_q    <= load_p1_q;
            if (sym_fire) begin
                sc_cnt_q <= 16'd0;
            end else if (active && i_data_vld) begin
                sc_cnt_q <= sc_wrap ? 16'd0 : sc_cnt_q + 16'd1;
            end
            if (bnd) begin
                rbg_cnt_q <= rbg_next;
            end
            // On underflow the previous vector is held
            if (replay && hit) begin
                beam_idx_q <= rd_data;
            end
        end
    end

`ifdef CW_RBG_SCHED_ERR_EN
    logic        err_q;
    logic [15:0] err_cnt_q;

    // Sticky underflow flag and saturating event counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            err_q     <= 1'b0;
            err_cnt_q <= 16'd0;
        end else if (replay && !hit) begin
            err_q <= 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign o_err_underflow = err_q;
    assign o_err_cnt       = err_cnt_q;
`else
    assign o_err_underflow = 1'b0;
    assign o_err_cnt       = 16'd0;
`endif

    assign o_cw_enable = cw_enable_q;
    assign o_symb_idx  = symb_idx_q;
    assign o_symb_clr  = symb_clr_q;
    assign o_symb_1st  = (symb_idx_q == 8'd0);
    assign o_beam_idx  = beam_idx_q;
    assign o_rbg_load  = load_q;
    assign o_rbg_idx   = rbg_cnt_q;

endmodule

// File: tb/tb_cw_rbg_sched.sv
// tb_cw_rbg_sched: scoreboard bench for cw_rbg_sched (small RBG_LEN/RBG_NUM).
module tb_cw_rbg_sched;

    localparam int unsigned BEAM     = 16;
    localparam int unsigned SYMB_NUM = 14;
    localparam int unsigned RBG_NUM  = 3;
    localparam int unsigned RBG_LEN  = 4;
    localparam int unsigned BW       = BEAM * 8;

    logic          i_clk;
    logic          i_reset;
    logic          i_slot_start;
    logic          i_sym_start;
    logic          i_data_vld;
    logic          i_beam_vld;
    logic [BW-1:0] i_beam_idx;
    logic          o_beam_rdy;
    logic          i_cw_tvalid;
    logic          o_cw_enable;
    logic [7:0]    o_symb_idx;
    logic          o_symb_clr;
    logic          o_symb_1st;
    logic [BW-1:0] o_beam_idx;
    logic          o_rbg_load;
    logic [7:0]    o_rbg_idx;
    logic          o_err_underflow;
    logic [15:0]   o_err_cnt;

    cw_rbg_sched #(
        .BEAM     (BEAM),
        .SYMB_NUM (SYMB_NUM),
        .RBG_NUM  (RBG_NUM),
        .RBG_LEN  (RBG_LEN)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_slot_start    (i_slot_start),
        .i_sym_start     (i_sym_start),
        .i_data_vld      (i_data_vld),
        .i_beam_vld      (i_beam_vld),
        .i_beam_idx      (i_beam_idx),
        .o_beam_rdy      (o_beam_rdy),
        .i_cw_tvalid     (i_cw_tvalid),
        .o_cw_enable     (o_cw_enable),
        .o_symb_idx      (o_symb_idx),
        .o_symb_clr      (o_symb_clr),
        .o_symb_1st      (o_symb_1st),
        .o_beam_idx      (o_beam_idx),
        .o_rbg_load      (o_rbg_load),
        .o_rbg_idx       (o_rbg_idx),
        .o_err_underflow (o_err_underflow),
        .o_err_cnt       (o_err_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        int            rbg;
        logic [BW-1:0] beam;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_vec = 0;
    int n_mis = 0;

    // Reference model state, expressed in terms of slots, symbols and RBGs
    bit            armed     = 1'b0;
    bit            in_run    = 1'b0;
    int            symcnt    = 0;
    int            symidx    = 0;
    int            nval      = -1;
    logic [BW-1:0] tbl[$];
    logic [BW-1:0] last_beam = '0;
    int            err_n     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h, need %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_w(input string name, input logic [BW-1:0] act,
                           input logic [BW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h, need %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [BW-1:0] rnd_beam();
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_reset();
        check("rst_cw_enable", 32'(o_cw_enable), 0);
        check("rst_symb_idx", 32'(o_symb_idx), 0);
        check("rst_symb_clr", 32'(o_symb_clr), 0);
        check("rst_symb_1st", 32'(o_symb_1st), 1);
        check_w("rst_beam_idx", o_beam_idx, '0);
        check("rst_rbg_load", 32'(o_rbg_load), 0);
        check("rst_rbg_idx", 32'(o_rbg_idx), 0);
        check("rst_beam_rdy", 32'(o_beam_rdy), 0);
        check("rst_err_uf", 32'(o_err_underflow), 0);
        check("rst_err_cnt", 32'(o_err_cnt), 0);
    endtask

    task automatic check_err();
`ifdef CW_RBG_SCHED_ERR_EN
        check("err_underflow", 32'(o_err_underflow), (err_n > 0) ? 1 : 0);
        check("err_cnt", 32'(o_err_cnt), (err_n > 65535) ? 65535 : err_n);
`else
        check("err_underflow", 32'(o_err_underflow), 0);
        check("err_cnt", 32'(o_err_cnt), 0);
`endif
    endtask

    // One cycle of stimulus; the model predicts acceptance and any replay load
    task automatic drive(input bit slot, input bit sym, input bit dv, input bit wr,
                         input logic [BW-1:0] wd);
        exp_t e;
        bit   bnd;
        int   k;
        bit   sym_run;
        i_slot_start = slot;
        i_sym_start  = sym;
        i_data_vld   = dv;
        i_beam_vld   = wr;
        i_beam_idx   = wd;
        if (wr) begin
            check("beam_rdy", 32'(o_beam_rdy), (in_run && tbl.size() < RBG_NUM) ? 1 : 0);
            if (in_run && tbl.size() < RBG_NUM) tbl.push_back(wd);
        end
        if (slot && armed) begin
            in_run = 1'b1;
            symcnt = 0;
            tbl.delete();
        end
        bnd     = 1'b0;
        k       = 0;
        sym_run = sym && in_run;
        if (sym_run) begin
            symidx = (symcnt < SYMB_NUM - 1) ? symcnt : SYMB_NUM - 1;
            symcnt++;
            nval = 0;
            bnd  = 1'b1;
        end else if (dv && in_run && nval >= 0) begin
            nval++;
            if ((nval % RBG_LEN) == 0 && (nval / RBG_LEN) < RBG_NUM) begin
                bnd = 1'b1;
                k   = nval / RBG_LEN;
            end
        end
        if (bnd && symidx >= 1) begin
            if (k < tbl.size()) last_beam = tbl[k];
            else err_n++;
            e.cyc  = cyc + 2;
            e.rbg  = k;
            e.beam = last_beam;
            exp_q.push_back(e);
        end
        tick();
        check("symb_clr", 32'(o_symb_clr), (slot && armed) ? 1 : 0);
        if (sym_run) begin
            check("symb_idx", 32'(o_symb_idx), symidx);
            check("symb_1st", 32'(o_symb_1st), (symidx == 0) ? 1 : 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic symbol(input int nv, input bit slot, input int wr_pct);
        drive(slot, 1'b1, 1'b1, !slot && ($urandom_range(99) < wr_pct), rnd_beam());
        for (int i = 1; i < nv; i++) begin
            repeat ($urandom_range(1)) drive(1'b0, 1'b0, 1'b0,
                                             $urandom_range(99) < wr_pct, rnd_beam());
            drive(1'b0, 1'b0, 1'b1, $urandom_range(99) < wr_pct, rnd_beam());
        end
        idle(RBG_LEN + 1);
    endtask

    task automatic preload();
        for (int c = 1; c <= 70; c++) begin
            i_slot_start = (c == 10);
            tick();
            check("cw_enable_hi", 32'(o_cw_enable), 1);
            check("symb_clr_preload", 32'(o_symb_clr), 0);
        end
        i_slot_start = 1'b0;
        i_cw_tvalid  = 1'b1;
        tick();
        i_cw_tvalid  = 1'b0;
        check("cw_enable_lo", 32'(o_cw_enable), 0);
        check("beam_rdy_wait", 32'(o_beam_rdy), 0);
        armed = 1'b1;
    endtask

    task automatic random_slot();
        int nsym;
        nsym = $urandom_range(5, 2);
        if ($urandom_range(1) == 0) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
            symbol($urandom_range(14, 1), 1'b0, 30);
        end else begin
            symbol($urandom_range(14, 1), 1'b1, 30);
        end
        for (int s = 1; s < nsym; s++) symbol($urandom_range(14, 1), 1'b0, 30);
    endtask

    // Monitor: compares every load strobe against the scoreboard head
    always @(negedge i_clk) begin
        if (o_rbg_load === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rbg_load_extra", 32'(o_rbg_load), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("load_cycle", cyc, mon_e.cyc);
                check("load_rbg_idx", 32'(o_rbg_idx), mon_e.rbg);
                check_w("load_beam_idx", o_beam_idx, mon_e.beam);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            check("rbg_load_missing", 32'(o_rbg_load), 1);
            mon_e = exp_q.pop_front();
        end
    end

    initial begin
        logic [BW-1:0] wd;
        i_reset      = 1'b1;
        i_slot_start = 1'b0;
        i_sym_start  = 1'b0;
        i_data_vld   = 1'b0;
        i_beam_vld   = 1'b0;
        i_beam_idx   = '0;
        i_cw_tvalid  = 1'b0;
        repeat (3) tick();
        check_reset();
        i_reset = 1'b0;
        preload();

        // Full slot: three entries 05/07/09, a fourth refused, replay on symbol 1
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            wd = rnd_beam();
            wd[7:0] = 8'(5 + 2 * i);
            drive(1'b0, 1'b0, 1'b1, 1'b1, wd);
        end
        idle(RBG_LEN + 1);
        symbol(12, 1'b0, 0);

        // Underflow: simultaneous slot/symbol start, one entry only
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, rnd_beam());
        idle(RBG_LEN + 1);
        symbol(12, 1'b0, 0);
        check_err();

        // Write and read of the same RBG in one cycle
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        symbol(1, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, rnd_beam());
        for (int i = 1; i < 9; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle(RBG_LEN + 1);

        // Symbol index saturation over 16 symbol starts
        symbol(1, 1'b1, 0);
        for (int s = 0; s < 15; s++) symbol(1, 1'b0, 0);

        for (int n = 0; n < 6; n++) random_slot();
        check_err();

        // Reset in the middle of symbol 2
        symbol(3, 1'b1, 50);
        symbol(5, 1'b0, 50);
        drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle(3);
        i_reset = 1'b1;
        tick();
        check_reset();
        armed     = 1'b0;
        in_run    = 1'b0;
        symcnt    = 0;
        symidx    = 0;
        nval      = -1;
        tbl.delete();
        last_beam = '0;
        err_n     = 0;
        i_reset   = 1'b0;
        tick();
        check("cw_enable_after_rst", 32'(o_cw_enable), 1);
        i_cw_tvalid = 1'b1;
        tick();
        i_cw_tvalid = 1'b0;
        check("cw_enable_lo2", 32'(o_cw_enable), 0);
        armed = 1'b1;
        random_slot();

        idle(10);
        check("pending_loads", exp_q.size(), 0);
        check_err();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
